// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the EX stage and the HI/LO mul/div sequencer.
// The EX side is the master; the sequencer is the slave.
interface hilo_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, rd_req, flush,
    input  busy, stall, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_req, flush,
    output busy, stall, done, dz, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Radix-2 multiply / restoring-divide sequencer owning the HI/LO pair.
// 32 RUN steps on magnitudes, then one FIX cycle applies signs and commits.
module hilo_muldiv_ctrl (
  input  logic         i_clk,
  input  logic         i_reset,
  hilo_muldiv_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_acc;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_bz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_dz;

  logic        w_busy;
  logic        w_stall;
  logic        w_idle_go;
  logic        w_issue;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_sign;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_div_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  // flush in IDLE suppresses every kind of issue, including MTHI/MTLO
  assign w_idle_go = (r_state == S_IDLE) && io_bus.start && !io_bus.flush;
  assign w_issue   = w_idle_go && !io_bus.op[2];
  assign w_mthi    = w_idle_go && (io_bus.op == OP_MTHI);
  assign w_mtlo    = w_idle_go && (io_bus.op == OP_MTLO);

  assign w_sign  = ~io_bus.op[0];
  assign w_a_abs = (w_sign && io_bus.a[31]) ? -io_bus.a : io_bus.a;
  assign w_b_abs = (w_sign && io_bus.b[31]) ? -io_bus.b : io_bus.b;

  assign w_sum     = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_nxt = {w_sum, r_acc[31:1]};

  // remainder after the left shift needs 33 bits before the compare
  assign w_rem_sh  = r_acc[63:31];
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_diff    = w_rem_sh[31:0] - r_b;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[30:0], 1'b1}
                          : {r_acc[62:0], 1'b0};

  assign w_prod = r_neg_q ? -r_acc : r_acc;

  always_comb begin
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_div) begin
      if (r_bz) begin
        w_fix_hi = 32'd0;
        w_fix_lo = 32'd0;
      end else begin
        w_fix_hi = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
        w_fix_lo = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (io_bus.flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_issue) w_next = S_RUN;
        S_RUN:   if (r_cnt == 5'd0) w_next = S_FIX;
        S_FIX:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_stall = w_busy && (io_bus.start || io_bus.rd_req);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc   <= 64'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_cnt   <= 5'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (w_issue) begin
        r_a     <= w_a_abs;
        r_b     <= w_b_abs;
        r_acc   <= io_bus.op[1] ? {32'd0, w_a_abs} : 64'd0;
        r_cnt   <= 5'd31;
        r_div   <= io_bus.op[1];
        r_neg_q <= w_sign && (io_bus.a[31] ^ io_bus.b[31]);
        r_neg_r <= w_sign && io_bus.a[31];
        r_bz    <= (io_bus.b == 32'd0);
      end
      if (w_mthi) r_hi <= io_bus.a;
      if (w_mtlo) r_lo <= io_bus.a;
      if ((r_state == S_RUN) && !io_bus.flush) begin
        r_acc <= r_div ? w_div_nxt : w_mul_nxt;
        if (!r_div) r_b <= r_b >> 1;
        if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
      end
      if ((r_state == S_FIX) && !io_bus.flush) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
        r_dz   <= r_div && r_bz;
      end
    end
  end

  assign io_bus.busy  = w_busy;
  assign io_bus.stall = w_stall;
  assign io_bus.done  = r_done;
  assign io_bus.dz    = r_dz;
  assign io_bus.hi    = r_hi;
  assign io_bus.lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized self-checking bench for hilo_muldiv_ctrl.
// Results come from plain 64-bit arithmetic; timing from the cycle rules.
module tb_hilo_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_if bus ();

  hilo_muldiv_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  // returns {dz, hi, lo}
  function automatic logic [64:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model = 65'd0;
    case (op)
      3'd0: begin p = sa * sb; model = {1'b0, p}; end
      3'd1: begin p = ua * ub; model = {1'b0, p}; end
      3'd2: begin
        if (b == 32'd0) model = {1'b1, 64'd0};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {1'b0, r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) model = {1'b1, 64'd0};
        else model = {1'b0, a % b, a / b};
      end
      default: model = 65'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.rd_req = 1'b0; bus.flush = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.stall} !== 4'd0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.busy, bus.done, bus.dz, bus.stall});
    end
    bus.rd_req = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    int bb = 0;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234;
    tick();
    bus.op = 3'd5; bus.a = 32'h5678;
    checks++;
    if (bus.hi !== 32'h1234) begin
      failures++;
      $display("FAIL mthi: got %h want 00001234", bus.hi);
    end
    if (bus.busy !== 1'b0) bb++;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678}) begin
      failures++;
      $display("FAIL mtlo: got %h want 0000123400005678", {bus.hi, bus.lo});
    end
    if (bus.busy !== 1'b0) bb++;
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hdeadbeef;
    tick();
    if (bus.busy !== 1'b0) bb++;
    bus.op = 3'd7;
    tick();
    if (bus.busy !== 1'b0) bb++;
    bus.op = 3'd4; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    if (bus.busy !== 1'b0) bb++;
    checks++;
    if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678}) begin
      failures++;
      $display("FAIL noop_flush_issue: got %h want 0000123400005678",
               {bus.hi, bus.lo});
    end
    checks++;
    if (bb != 0) begin
      failures++;
      $display("FAIL mt_busy: got %0d busy cycles want 0", bb);
    end
    m_hi = 32'h1234;
    m_lo = 32'h5678;
  endtask

  task automatic test_rdreq_idle();
    bus.rd_req = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.hi !== m_hi) begin
      failures++;
      $display("FAIL rdreq_idle: got stall=%b hi=%h want stall=0 hi=%h",
               bus.stall, bus.hi, m_hi);
    end
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_muldiv();
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd0, 3'd3};
    logic [31:0] as  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'h80000000, 32'd7, 32'hFFFFFFF0,
                             32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [8] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF,
                             32'd0, 32'd0, 32'h80000000, 32'd1};
    for (int v = 0; v < 32; v++) begin
      logic [2:0]  opv;
      logic [31:0] av, bv, ghi, glo;
      logic [64:0] exp;
      logic        gdz;
      int          done_k, bad_prof, bad_dz;
      if (v < 8) begin
        opv = ops[v]; av = as[v]; bv = bs[v];
      end else begin
        opv = 3'($urandom_range(0, 3));
        av  = $urandom;
        bv  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        if (v % 5 == 0) bv = 32'($urandom_range(1, 9));
      end
      exp = model(opv, av, bv);
      bus.start = 1'b1; bus.op = opv; bus.a = av; bus.b = bv;
      tick();
      bus.start = 1'b0;
      done_k = 0; bad_prof = 0; bad_dz = 0;
      ghi = 32'd0; glo = 32'd0; gdz = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        bus.rd_req = 1'($urandom_range(0, 1));
        #1;
        if (bus.busy !== (k <= 33)) bad_prof++;
        if (bus.stall !== ((k <= 33) && bus.rd_req)) bad_prof++;
        if (bus.done === 1'b1) begin
          done_k = k; ghi = bus.hi; glo = bus.lo; gdz = bus.dz;
          break;
        end
        if (bus.dz !== 1'b0) bad_dz++;
        tick();
      end
      bus.rd_req = 1'b0;
      checks++;
      if (done_k != 34) begin
        failures++;
        $display("FAIL done_cycle v%0d: got %0d want 34", v, done_k);
      end
      checks++;
      if (bad_prof != 0 || bad_dz != 0) begin
        failures++;
        $display("FAIL busy_stall_dz v%0d: got %0d/%0d bad cycles want 0",
                 v, bad_prof, bad_dz);
      end
      checks++;
      if ({gdz, ghi, glo} !== exp) begin
        failures++;
        $display("FAIL result v%0d op%0d a=%h b=%h: got dz=%b %h_%h want dz=%b %h_%h",
                 v, opv, av, bv, gdz, ghi, glo, exp[64], exp[63:32], exp[31:0]);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.dz !== 1'b0) begin
        failures++;
        $display("FAIL done_width v%0d: got done=%b dz=%b want 0 0",
                 v, bus.done, bus.dz);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv, ghi, glo;
    logic [64:0] e1, e2;
    int done_k, bad;
    av = $urandom;
    bv = 32'($urandom_range(1, 1000));
    e1 = model(3'd2, av, bv);
    e2 = model(3'd0, 32'd2, 32'd3);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = av; bus.b = bv;
    tick();
    bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd3; bus.rd_req = 1'b1;
    done_k = 0; bad = 0; ghi = 32'd0; glo = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (k <= 33 && (bus.stall !== 1'b1 || bus.busy !== 1'b1)) bad++;
      if (bus.done === 1'b1) begin
        done_k = k; ghi = bus.hi; glo = bus.lo;
        break;
      end
      tick();
    end
    checks++;
    if (bad != 0 || done_k != 34) begin
      failures++;
      $display("FAIL b2b_stall: got %0d bad, done at %0d want 0, 34", bad, done_k);
    end
    checks++;
    if ({ghi, glo} !== e1[63:0] || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_div: got %h stall=%b want %h stall=0",
               {ghi, glo}, bus.stall, e1[63:0]);
    end
    tick();
    bus.start = 1'b0; bus.rd_req = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
    end
    done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) #1;
      if (bus.done === 1'b1) begin
        done_k = k; ghi = bus.hi; glo = bus.lo;
        break;
      end
      tick();
    end
    checks++;
    if (done_k != 34 || {ghi, glo} !== e2[63:0]) begin
      failures++;
      $display("FAIL b2b_mult: got done at %0d %h want 34 %h",
               done_k, {ghi, glo}, e2[63:0]);
    end
    m_hi = ghi;
    m_lo = glo;
    tick();
  endtask

  task automatic test_flush();
    for (int f = 0; f < 2; f++) begin
      int fc, nd;
      fc = (f == 0) ? 10 : 33;
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA;
      tick();
      bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k < fc; k++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL flush_c%0d_busy: got busy=%b done=%b want 0 0",
                 fc, bus.busy, bus.done);
      end
      nd = 0;
      for (int k = 0; k < 40; k++) begin
        if (bus.done !== 1'b0) nd++;
        tick();
      end
      checks++;
      if (nd != 0 || bus.hi !== 32'hAAAA || bus.lo !== m_lo) begin
        failures++;
        $display("FAIL flush_c%0d_hold: got done_cnt=%0d hi=%h lo=%h want 0 0000aaaa %h",
                 fc, nd, bus.hi, bus.lo, m_lo);
      end
      m_hi = 32'hAAAA;
    end
  endtask

  task automatic test_reset_abort();
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA;
    tick();
    bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got busy=%b want 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0 ||
        {bus.busy, bus.done, bus.dz, bus.stall} !== 4'd0) begin
      failures++;
      $display("FAIL reset_abort: got %h flags=%b want 0 0000",
               {bus.hi, bus.lo}, {bus.busy, bus.done, bus.dz, bus.stall});
    end
    rst = 1'b0;
    tick();
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_rdreq_idle();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
